// File: rtl/morse_key_decoder.sv
// Morse key receiver: times key_in marks and spaces in Morse units, then emits 5-bit character codes and word-gap spaces.
// Optional macro MORSE_DEC_GLITCH_FILTER_EN discards marks shorter than max(1, UNIT_CYCLES/4).
module morse_key_decoder #(
  parameter int UNIT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [4:0] char_code,
  output logic       char_valid,
  output logic       char_err,
  output logic       busy
);
  localparam int CW = $clog2(8*UNIT_CYCLES + 1);
  localparam logic [CW-1:0] SAT      = CW'(8*UNIT_CYCLES);
  localparam logic [CW-1:0] DASH_LEN = CW'(2*UNIT_CYCLES);
  // cnt excludes the current cycle, so a low run reaches N on the cycle cnt == N-1
  localparam logic [CW-1:0] CHR_END  = CW'(2*UNIT_CYCLES - 1);
  localparam logic [CW-1:0] WRD_END  = CW'(5*UNIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  state_t        state, prev;
  logic          k1, key_s, key_d;
  logic [CW-1:0] cnt;
  logic [3:0]    sr;
  logic [2:0]    nsym;
  logic          ovf;
  logic          rise, fall, glitch;
  logic [4:0]    dec;

  assign rise = key_s & ~key_d;
  assign fall = ~key_s & key_d;

`ifdef MORSE_DEC_GLITCH_FILTER_EN
  localparam logic [CW-1:0] GLITCH_LEN = CW'((UNIT_CYCLES/4 < 1) ? 1 : UNIT_CYCLES/4);
  assign glitch = (cnt < GLITCH_LEN);
`else
  assign glitch = 1'b0;
`endif

  // International Morse A-Z, dot=0 dash=1, first symbol is the MSB of the nsym-bit pattern
  function automatic logic [4:0] lookup(input logic [2:0] n, input logic [3:0] p);
    case ({n, p})
      {3'd2, 4'b0001}: lookup = 5'd1;
      {3'd4, 4'b1000}: lookup = 5'd2;
      {3'd4, 4'b1010}: lookup = 5'd3;
      {3'd3, 4'b0100}: lookup = 5'd4;
      {3'd1, 4'b0000}: lookup = 5'd5;
      {3'd4, 4'b0010}: lookup = 5'd6;
      {3'd3, 4'b0110}: lookup = 5'd7;
      {3'd4, 4'b0000}: lookup = 5'd8;
      {3'd2, 4'b0000}: lookup = 5'd9;
      {3'd4, 4'b0111}: lookup = 5'd10;
      {3'd3, 4'b0101}: lookup = 5'd11;
      {3'd4, 4'b0100}: lookup = 5'd12;
      {3'd2, 4'b0011}: lookup = 5'd13;
      {3'd2, 4'b0010}: lookup = 5'd14;
      {3'd3, 4'b0111}: lookup = 5'd15;
      {3'd4, 4'b0110}: lookup = 5'd16;
      {3'd4, 4'b1101}: lookup = 5'd17;
      {3'd3, 4'b0010}: lookup = 5'd18;
      {3'd3, 4'b0000}: lookup = 5'd19;
      {3'd1, 4'b0001}: lookup = 5'd20;
      {3'd3, 4'b0001}: lookup = 5'd21;
      {3'd4, 4'b0001}: lookup = 5'd22;
      {3'd3, 4'b0011}: lookup = 5'd23;
      {3'd4, 4'b1001}: lookup = 5'd24;
      {3'd4, 4'b1011}: lookup = 5'd25;
      {3'd4, 4'b1100}: lookup = 5'd26;
      default:         lookup = 5'd31;
    endcase
  endfunction

  assign dec = lookup(nsym, sr);

  always_ff @(posedge clk) begin
    if (rst) begin
      k1    <= 1'b0;
      key_s <= 1'b0;
      key_d <= 1'b0;
      cnt   <= '0;
    end else begin
      k1    <= key_in;
      key_s <= k1;
      key_d <= key_s;
      if (key_s != key_d) cnt <= CW'(1);
      else if (cnt != SAT) cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= IDLE;
      sr         <= '0;
      nsym       <= '0;
      ovf        <= 1'b0;
      char_code  <= '0;
      char_valid <= 1'b0;
      char_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      char_err   <= 1'b0;
      case (state)
        IDLE: if (rise) begin
          state <= MARK;
          prev  <= IDLE;
          busy  <= 1'b1;
          sr    <= '0;
          nsym  <= '0;
          ovf   <= 1'b0;
        end
        MARK: if (fall) begin
          if (glitch) begin
            state <= prev;
            busy  <= (prev != IDLE);
          end else begin
            state <= SPACE;
            if (nsym == 3'd4) ovf <= 1'b1;
            else begin
              sr   <= {sr[2:0], (cnt >= DASH_LEN)};
              nsym <= nsym + 3'd1;
            end
          end
        end
        SPACE: begin
          if (rise) begin
            state <= MARK;
            prev  <= SPACE;
          end else if (!key_s && cnt >= CHR_END) begin
            state      <= GAP;
            char_valid <= 1'b1;
            char_code  <= ovf ? 5'd31 : dec;
            char_err   <= ovf || (dec == 5'd31);
          end
        end
        GAP: begin
          if (rise) begin
            state <= MARK;
            prev  <= GAP;
            sr    <= '0;
            nsym  <= '0;
            ovf   <= 1'b0;
          end else if (!key_s && cnt >= WRD_END) begin
            state      <= IDLE;
            busy       <= 1'b0;
            char_valid <= 1'b1;
            char_code  <= 5'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder at UNIT_CYCLES=8: strobes are logged at negedge and checked against hand-computed codes and cycles.
module tb_morse_key_decoder;
  logic       clk = 1'b0;
  logic       rst, key_in;
  logic [4:0] char_code;
  logic       char_valid, char_err, busy;

  int checks = 0, failures = 0, cyc = 0, c_fall = 0;
  int q_code[$], q_err[$], q_cyc[$];

  morse_key_decoder #(.UNIT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .char_code(char_code), .char_valid(char_valid), .char_err(char_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (char_valid) begin
    q_code.push_back(int'(char_code));
    q_err.push_back(int'(char_err));
    q_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic key(input logic lv, input int n);
    key_in = lv;
    if (!lv) c_fall = cyc;
    tick(n);
  endtask

  task automatic clear_q();
    q_code.delete(); q_err.delete(); q_cyc.delete();
  endtask

  // key_s falls 2 cycles after the drive; char at +16 low cycles, space at +40
  task automatic expect_seq(input string tag, input int code, input int err);
    check({tag, "_nstrobe"}, q_code.size(), 2);
    if (q_code.size() == 2) begin
      check({tag, "_code"},  q_code[0], code);
      check({tag, "_err"},   q_err[0],  err);
      check({tag, "_cyc"},   q_cyc[0],  c_fall + 18);
      check({tag, "_sp"},    q_code[1], 0);
      check({tag, "_sperr"}, q_err[1],  0);
      check({tag, "_spcyc"}, q_cyc[1],  c_fall + 42);
    end
    check({tag, "_busy"}, int'(busy), 0);
    clear_q();
  endtask

  initial begin
    rst = 1'b1; key_in = 1'b1;
    tick(3);
    check("rst_code",  int'(char_code),  0);
    check("rst_valid", int'(char_valid), 0);
    check("rst_err",   int'(char_err),   0);
    check("rst_busy",  int'(busy),       0);
    rst = 1'b0; key_in = 1'b0;
    tick(10);
    check("idle_busy", int'(busy), 0);
    check("idle_nstrobe", q_code.size(), 0);
    clear_q();

    // A = .-
    key(1, 8);
    check("a_busy_mid", int'(busy), 1);
    key(0, 8); key(1, 24); key(0, 60);
    expect_seq("a", 1, 0);

    key(1, 8); key(0, 60);
    expect_seq("e", 5, 0);

    key(1, 15); key(0, 60);
    expect_seq("bnd15", 5, 0);
    key(1, 16); key(0, 60);
    expect_seq("bnd16", 20, 0);

    repeat (4) begin key(1, 8); key(0, 8); end
    key(1, 8); key(0, 60);
    expect_seq("five_dots", 31, 1);

    key(1, 8); key(0, 8); key(1, 8); key(0, 8);
    key(1, 24); key(0, 8); key(1, 24); key(0, 60);
    expect_seq("ddaa", 31, 1);

    key(1, 1); key(0, 60);
`ifdef MORSE_DEC_GLITCH_FILTER_EN
    check("glitch_nstrobe", q_code.size(), 0);
    check("glitch_busy", int'(busy), 0);
    clear_q();
`else
    expect_seq("glitch", 5, 0);
`endif

    key(1, 10);
    check("mid_busy", int'(busy), 1);
    rst = 1'b1; key_in = 1'b0;
    tick(1);
    check("mid_rst_code",  int'(char_code),  0);
    check("mid_rst_valid", int'(char_valid), 0);
    check("mid_rst_err",   int'(char_err),   0);
    check("mid_rst_busy",  int'(busy),       0);
    rst = 1'b0;
    tick(10);
    check("mid_rst_nstrobe", q_code.size(), 0);
    clear_q();
    key(1, 24); key(0, 60);
    expect_seq("t_after_rst", 20, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
